time_set_ctrl: RTL

- Mode/edit controller that sequences the 24-hour BCD HH:MM:SS time counter.
- Gates the counter's count enable and captures the live time into shadow registers.
- Lets the user step hours, then minutes, with two pre-debounced button pulses, then commits the edited time through a one-cycle parallel load with seconds cleared to 00.
- Sits between the button front-end and the time counter, in the same clock domain.

---
 rtl/time_set_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// Mode/edit controller for the 24-hour BCD time counter: captures the live time,
// steps hours then minutes, and commits via a one-cycle load. Optional macro: SET_TIMEOUT_EN.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_ms_hr,
  input  logic [3:0] cur_ls_hr,
  input  logic [3:0] cur_ms_min,
  input  logic [3:0] cur_ls_min,
  output logic       cnt_en,
  output logic       load,
  output logic [3:0] ld_ms_hr,
  output logic [3:0] ld_ls_hr,
  output logic [3:0] ld_ms_min,
  output logic [3:0] ld_ls_min,
  output logic [3:0] ld_ms_sec,
  output logic [3:0] ld_ls_sec,
  output logic       set_hr,
  output logic       set_min,
  output logic       blink
);

  typedef enum logic [1:0] {StRun, StSetHr, StSetMin, StCommit} state_e;

  state_e     state_d, state_q;
  logic [7:0] hr_d, hr_q, min_d, min_q;
  logic [7:0] ld_hr_d, ld_hr_q, ld_min_d, ld_min_q;
  logic       cnt_en_d, cnt_en_q;
  logic       load_d, load_q;
  logic       set_hr_d, set_hr_q;
  logic       set_min_d, set_min_q;
  logic       blink_d, blink_q;
  logic       in_edit;
  logic       to_hit;

  // Out-of-range (including non-BCD) values restart from 00.
  function automatic logic [7:0] step_hr(input logic [7:0] v);
    if (v[7:4] > 4'd2 || v[3:0] > 4'd9 || (v[7:4] == 4'd2 && v[3:0] >= 4'd3)) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic logic [7:0] step_min(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9 || (v[7:4] == 4'd5 && v[3:0] == 4'd9)) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  assign in_edit = (state_q == StSetHr) || (state_q == StSetMin);

`ifdef SET_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);

  logic [ToW-1:0] to_cnt_d, to_cnt_q;

  // The terminal tick abandons the edit unless a button arrives in the same cycle.
  assign to_hit = in_edit && tick && !mode_btn && !inc_btn &&
                  (to_cnt_q == ToW'(TIMEOUT_TICKS - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!in_edit || mode_btn || inc_btn || to_hit) begin
      to_cnt_d = '0;
    end else if (tick) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_ticks;
  assign unused_timeout_ticks = (TIMEOUT_TICKS != 0);
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    unique case (state_q)
      StRun: begin
        if (mode_btn) begin
          state_d = StSetHr;
          hr_d    = {cur_ms_hr, cur_ls_hr};
          min_d   = {cur_ms_min, cur_ls_min};
        end
      end
      StSetHr: begin
        if (mode_btn) begin
          state_d = StSetMin;
        end else if (inc_btn) begin
          hr_d = step_hr(hr_q);
        end
      end
      StSetMin: begin
        if (mode_btn) begin
          state_d = StCommit;
        end else if (inc_btn) begin
          min_d = step_min(min_q);
        end
      end
      StCommit: state_d = StRun;
    endcase
    if (to_hit) begin
      state_d = StRun;
    end

    cnt_en_d  = (state_d == StRun);
    load_d    = (state_d == StCommit);
    set_hr_d  = (state_d == StSetHr);
    set_min_d = (state_d == StSetMin);
    ld_hr_d   = load_d ? hr_q : ld_hr_q;
    ld_min_d  = load_d ? min_q : ld_min_q;

    if (state_d != StSetHr && state_d != StSetMin) begin
      blink_d = 1'b0;
    end else if (state_q == StRun) begin
      blink_d = 1'b0;
    end else begin
      blink_d = blink_q ^ tick;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StRun;
      hr_q      <= '0;
      min_q     <= '0;
      ld_hr_q   <= '0;
      ld_min_q  <= '0;
      cnt_en_q  <= 1'b1;
      load_q    <= 1'b0;
      set_hr_q  <= 1'b0;
      set_min_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      ld_hr_q   <= ld_hr_d;
      ld_min_q  <= ld_min_d;
      cnt_en_q  <= cnt_en_d;
      load_q    <= load_d;
      set_hr_q  <= set_hr_d;
      set_min_q <= set_min_d;
      blink_q   <= blink_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign load      = load_q;
  assign ld_ms_hr  = ld_hr_q[7:4];
  assign ld_ls_hr  = ld_hr_q[3:0];
  assign ld_ms_min = ld_min_q[7:4];
  assign ld_ls_min = ld_min_q[3:0];
  // Commit always restarts the minute at :00.
  assign ld_ms_sec = 4'd0;
  assign ld_ls_sec = 4'd0;
  assign set_hr    = set_hr_q;
  assign set_min   = set_min_q;
  assign blink     = blink_q;

endmodule
